// File: rtl/ramp_seq_pkg.sv
// Shared types and default widths for the triangle ramp sequencer.
package ramp_seq_pkg;

   localparam int RS_WIDTH  = 4;
   localparam int RS_HOLD_W = 4;
   localparam int RS_REP_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_UP      = 3'd1,
      S_HOLD_HI = 3'd2,
      S_DOWN    = 3'd3,
      S_HOLD_LO = 3'd4,
      S_DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/ud_counter_ld.sv
// Loadable up/down counter; load wins over count enable.
module ud_counter_ld #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en)
         count <= dir ? count + WIDTH'(1) : count - WIDTH'(1);
   end

endmodule

// File: rtl/ramp_sequencer.sv
// Triangle ramp sequencer: lo->hi, dwell, hi->lo, dwell, repeated reps times.
module ramp_sequencer
   import ramp_seq_pkg::*;
#(
   parameter int WIDTH  = RS_WIDTH,
   parameter int HOLD_W = RS_HOLD_W,
   parameter int REP_W  = RS_REP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WIDTH-1:0]  lo,
   input  logic [WIDTH-1:0]  hi,
   input  logic [HOLD_W-1:0] hold,
   input  logic [REP_W-1:0]  reps,
   output logic [WIDTH-1:0]  count,
   output logic              dir,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              aborted
);

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    lo_q, hi_q;
   logic [HOLD_W-1:0]   hold_q, timer_q, timer_d;
   logic [REP_W-1:0]    reps_q, rep_q, rep_d, reps_eff;
   logic                dir_q, dir_d, err_q, err_d, ab_q, ab_d;
   logic                latch, cnt_ld, cnt_en, cnt_dir;
   logic [WIDTH-1:0]    cnt_inc, cnt_dec;

   assign cnt_inc  = count + WIDTH'(1);
   assign cnt_dec  = count - WIDTH'(1);
   assign reps_eff = (reps_q == '0) ? REP_W'(1) : reps_q;

   ud_counter_ld #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_ld),
      .load_val (lo),
      .en       (cnt_en),
      .dir      (cnt_dir),
      .count    (count)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rep_d   = rep_q;
      err_d   = err_q;
      ab_d    = 1'b0;
      latch   = 1'b0;
      cnt_ld  = 1'b0;
      cnt_en  = 1'b0;
      cnt_dir = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               latch = 1'b1;
               rep_d = '0;
               if (lo >= hi) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_UP;
                  err_d   = 1'b0;
                  cnt_ld  = 1'b1;
               end
            end
         end
         S_UP: begin
            cnt_en = 1'b1;
            if (cnt_inc == hi_q) begin
               if (hold_q == '0) begin
                  state_d = S_DOWN;
               end else begin
                  state_d = S_HOLD_HI;
                  timer_d = hold_q - HOLD_W'(1);
               end
            end
         end
         S_HOLD_HI: begin
            if (timer_q == '0) state_d = S_DOWN;
            else timer_d = timer_q - HOLD_W'(1);
         end
         S_DOWN: begin
            cnt_en  = 1'b1;
            cnt_dir = 1'b0;
            if (cnt_dec == lo_q) begin
               rep_d = rep_q + REP_W'(1);
               if (rep_d == reps_eff) begin
                  state_d = S_DONE;
               end else if (hold_q == '0) begin
                  state_d = S_UP;
               end else begin
                  state_d = S_HOLD_LO;
                  timer_d = hold_q - HOLD_W'(1);
               end
            end
         end
         S_HOLD_LO: begin
            if (timer_q == '0) state_d = S_UP;
            else timer_d = timer_q - HOLD_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // abort beats every other transition and freezes the counter
      if (abort && busy) begin
         state_d = S_IDLE;
         timer_d = timer_q;
         rep_d   = rep_q;
         cnt_en  = 1'b0;
         ab_d    = 1'b1;
      end
      unique case (state_d)
         S_UP, S_HOLD_HI:   dir_d = 1'b1;
         S_DOWN, S_HOLD_LO: dir_d = 1'b0;
         default:           dir_d = dir_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         rep_q   <= '0;
         dir_q   <= 1'b1;
         err_q   <= 1'b0;
         ab_q    <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
         hold_q  <= '0;
         reps_q  <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         rep_q   <= rep_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
         ab_q    <= ab_d;
         if (latch) begin
            lo_q   <= lo;
            hi_q   <= hi;
            hold_q <= hold;
            reps_q <= reps;
         end
      end
   end

   assign busy    = (state_q == S_UP) || (state_q == S_HOLD_HI) ||
                    (state_q == S_DOWN) || (state_q == S_HOLD_LO);
   assign done    = (state_q == S_DONE);
   assign err     = done && err_q;
   assign dir     = dir_q;
   assign aborted = ab_q;

endmodule

// File: tb/tb_ramp_sequencer.sv
// Directed and randomized checks of ramp_sequencer against a trace model.
module tb_ramp_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [3:0] lo, hi, hold, reps;
   logic [3:0] count;
   logic       dir, busy, done, err, aborted;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0] c;
      logic       d;
      logic       b;
      logic       dn;
      logic       e;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] m_count;
   logic       m_dir;

   ramp_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .lo(lo), .hi(hi), .hold(hold), .reps(reps),
      .count(count), .dir(dir), .busy(busy), .done(done),
      .err(err), .aborted(aborted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input int c, d, b, dn, e);
      exp_t x;
      x.c = c[3:0]; x.d = d[0]; x.b = b[0]; x.dn = dn[0]; x.e = e[0];
      return x;
   endfunction

   // Expected per-cycle trace, starting with the cycle after start is taken.
   task automatic build(input int l, h, hd, rp);
      int eff;
      exp_q.delete();
      if (l >= h) begin
         exp_q.push_back(mk(m_count, m_dir, 0, 1, 1));
         return;
      end
      eff = (rp == 0) ? 1 : rp;
      for (int r = 1; r <= eff; r++) begin
         for (int v = l; v < h; v++) exp_q.push_back(mk(v, 1, 1, 0, 0));
         for (int k = 0; k < hd; k++) exp_q.push_back(mk(h, 1, 1, 0, 0));
         exp_q.push_back(mk(h, 0, 1, 0, 0));
         for (int v = h - 1; v > l; v--) exp_q.push_back(mk(v, 0, 1, 0, 0));
         if (r == eff) exp_q.push_back(mk(l, 0, 0, 1, 0));
         else for (int k = 0; k < hd; k++) exp_q.push_back(mk(l, 0, 1, 0, 0));
      end
   endtask

   task automatic chk_entry(input string tag, input exp_t x);
      chk({tag, ".count"}, count, x.c);
      chk({tag, ".dir"}, dir, x.d);
      chk({tag, ".busy"}, busy, x.b);
      chk({tag, ".done"}, done, x.dn);
      chk({tag, ".err"}, err, x.e);
      chk({tag, ".aborted"}, aborted, 0);
   endtask

   task automatic run_seq(input string tag, input int l, h, hd, rp,
                          input bit scramble);
      lo = l[3:0]; hi = h[3:0]; hold = hd[3:0]; reps = rp[3:0];
      start = 1'b1;
      build(l, h, hd, rp);
      step();
      start = 1'b0;
      foreach (exp_q[i]) begin
         chk_entry(tag, exp_q[i]);
         m_count = exp_q[i].c;
         m_dir   = exp_q[i].d;
         if (scramble) begin
            start = 1'($urandom_range(0, 1));
            lo = 4'($urandom); hi = 4'($urandom);
            hold = 4'($urandom); reps = 4'($urandom);
         end
         step();
      end
      chk_entry({tag, ".idle"}, mk(m_count, m_dir, 0, 0, 0));
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      lo = '0; hi = '0; hold = '0; reps = '0;
      step(); step();
      rst = 1'b0;
      m_count = 4'd0; m_dir = 1'b1;
      chk_entry("reset", mk(0, 1, 0, 0, 0));
      step();
      chk_entry("reset_idle", mk(0, 1, 0, 0, 0));

      run_seq("basic", 2, 5, 0, 1, 0);
      run_seq("hold_reps", 2, 5, 2, 2, 0);
      run_seq("full", 0, 15, 0, 1, 0);
      run_seq("eq_bounds", 5, 5, 3, 1, 0);
      run_seq("inv_bounds", 9, 3, 0, 2, 0);
      run_seq("reps0", 3, 6, 1, 0, 0);
      run_seq("latched", 1, 7, 1, 2, 1);

      // abort while counting up
      lo = 4'd2; hi = 4'd9; hold = 4'd1; reps = 4'd1; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      chk("abort.pre_count", count, 4);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort.count", count, 4);
      chk("abort.busy", busy, 0);
      chk("abort.aborted", aborted, 1);
      chk("abort.done", done, 0);
      chk("abort.dir", dir, 1);
      step();
      chk("abort.pulse_end", aborted, 0);
      chk("abort.hold_count", count, 4);
      chk("abort.no_done", done, 0);
      m_count = 4'd4; m_dir = 1'b1;
      run_seq("after_abort", 4, 8, 0, 1, 0);

      // abort in DONE completes normally
      lo = 4'd7; hi = 4'd7; start = 1'b1;
      step();
      start = 1'b0;
      chk("done_abort.done", done, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("done_abort.aborted", aborted, 0);
      chk("done_abort.busy", busy, 0);

      // start while busy is ignored, then reset mid-DOWN
      lo = 4'd1; hi = 4'd4; hold = 4'd0; reps = 4'd1; start = 1'b1;
      step();
      lo = 4'd0; hi = 4'd15;
      step();
      start = 1'b0;
      chk("midstart.count", count, 2);
      step();
      chk("midstart.count2", count, 3);
      step();
      chk("midstart.hi", count, 4);
      chk("midstart.dir", dir, 0);
      step();
      chk("rst.pre_count", count, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_entry("rst_mid", mk(0, 1, 0, 0, 0));
      m_count = 4'd0; m_dir = 1'b1;

      for (int n = 0; n < 25; n++) begin
         run_seq("rand", $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
